// File: rtl/axis_uart_tx_arbiter.sv
// Purpose: packet-level round-robin arbiter sharing one AXI-Stream UART input between NUM_SRC sources.
// Latency: 1 cycle to arbitrate in IDLE, then combinational pass-through of the granted source in XFER.
// Backpressure: m_axis_ready is routed only to the granted source; stalls from the UART do not age the watchdog.
//
// Ports:
//   clk, rst_n                       rising-edge clock, synchronous active-low reset
//   s_axis_data/valid/last/ready     per-source streams (data flat, source i at [i*DATA_BITS +: DATA_BITS])
//   m_axis_data/valid/last/ready     stream to the UART core
//   grant_id                         current or most recent owner
//   busy                             high while a grant is held
//   stall_err                        one-cycle pulse when the watchdog revokes a grant
module axis_uart_tx_arbiter #(
    parameter int NUM_SRC       = 4,
    parameter int DATA_BITS     = 8,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC*DATA_BITS-1:0]   s_axis_data,
    input  logic [NUM_SRC-1:0]             s_axis_valid,
    input  logic [NUM_SRC-1:0]             s_axis_last,
    output logic [NUM_SRC-1:0]             s_axis_ready,
    output logic [DATA_BITS-1:0]           m_axis_data,
    output logic                           m_axis_valid,
    output logic                           m_axis_last,
    input  logic                           m_axis_ready,
    output logic [$clog2(NUM_SRC)-1:0]     grant_id,
    output logic                           busy,
    output logic                           stall_err
);

    localparam int GW = $clog2(NUM_SRC);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [GW-1:0]   last_grant_q;
    logic [GW-1:0]   grant_q;
    logic [15:0]     stall_cnt_q;
    logic            stall_err_q;

    // Per-source data unpacked so the granted lane can be picked by index.
    logic [DATA_BITS-1:0] src_data [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = s_axis_data[i*DATA_BITS +: DATA_BITS];
    end

    // Granted-source view.
    logic                 g_valid;
    logic                 g_last;
    logic [DATA_BITS-1:0] g_data;

    assign g_valid = s_axis_valid[grant_q];
    assign g_last  = s_axis_last[grant_q];
    assign g_data  = src_data[grant_q];

    // Outputs are also forced quiet while reset is held, not just after the edge.
    logic xfer_act;
    logic hs;
    logic pkt_done;
    logic stall_hit;
    logic [16:0] stall_cnt_inc;

    assign xfer_act      = (state_q == XFER) && rst_n;
    assign hs            = xfer_act && g_valid && m_axis_ready;
    assign pkt_done      = hs && g_last;
    assign stall_cnt_inc = {1'b0, stall_cnt_q} + 17'd1;
    // This cycle is the STALL_TIMEOUT-th consecutive cycle without valid from the owner.
    assign stall_hit     = xfer_act && !g_valid && (stall_cnt_inc == 17'(STALL_TIMEOUT));

    // Rotating priority: scan last_grant+1, last_grant+2, ... wrapping at NUM_SRC.
    logic          any_req;
    logic [GW-1:0] winner;

    assign any_req = |s_axis_valid;

    always_comb begin
        int            cand;
        logic [GW-1:0] cand_idx;
        logic          found;
        cand     = 0;
        cand_idx = '0;
        found    = 1'b0;
        winner   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NUM_SRC) begin
                cand = cand - NUM_SRC;
            end
            cand_idx = GW'(cand);
            if (!found && s_axis_valid[cand_idx]) begin
                found  = 1'b1;
                winner = cand_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. IDLE is never skipped between packets.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (pkt_done || stall_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping and stall watchdog.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= GW'(NUM_SRC - 1);
            grant_q      <= '0;
            stall_cnt_q  <= '0;
            stall_err_q  <= 1'b0;
        end else begin
            stall_err_q <= stall_hit;
            case (state_q)
                IDLE: begin
                    stall_cnt_q <= '0;
                    if (any_req) begin
                        grant_q <= winner;
                    end
                end
                XFER: begin
                    if (pkt_done || stall_hit) begin
                        last_grant_q <= grant_q;
                    end
                    // Only an absent owner ages the counter; UART backpressure does not.
                    if (g_valid || stall_hit) begin
                        stall_cnt_q <= '0;
                    end else begin
                        stall_cnt_q <= stall_cnt_q + 16'd1;
                    end
                end
                default: stall_cnt_q <= '0;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        m_axis_data  = '0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        s_axis_ready = '0;
        busy         = 1'b0;
        if (xfer_act) begin
            m_axis_data           = g_data;
            m_axis_valid          = g_valid;
            m_axis_last           = g_last;
            s_axis_ready[grant_q] = m_axis_ready;
            busy                  = 1'b1;
        end
    end

    assign grant_id  = grant_q;
    assign stall_err = stall_err_q;

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Purpose: self-checking bench for axis_uart_tx_arbiter with 4 sources of 8-bit data.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: m_axis_ready is driven by the bench, randomly in the round-robin scenario.
module tb_axis_uart_tx_arbiter;

    localparam int NS  = 4;
    localparam int DB  = 8;
    localparam int STO = 255;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NS*DB-1:0] s_data;
    logic [NS-1:0]   s_valid;
    logic [NS-1:0]   s_last;
    logic [NS-1:0]   s_ready;
    logic [DB-1:0]   m_data;
    logic            m_valid;
    logic            m_last;
    logic            m_ready;
    logic [1:0]      grant_id;
    logic            busy;
    logic            stall_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axis_uart_tx_arbiter #(
        .NUM_SRC       (NS),
        .DATA_BITS     (DB),
        .STALL_TIMEOUT (STO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_data  (s_data),
        .s_axis_valid (s_valid),
        .s_axis_last  (s_last),
        .s_axis_ready (s_ready),
        .m_axis_data  (m_data),
        .m_axis_valid (m_valid),
        .m_axis_last  (m_last),
        .m_axis_ready (m_ready),
        .grant_id     (grant_id),
        .busy         (busy),
        .stall_err    (stall_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = '1;
        s_last  = '1;
        s_data  = $urandom;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({m_valid, m_last, m_data, s_ready, busy, grant_id, stall_err} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%h r=%b busy=%b g=%0d se=%b required all zero",
                     m_valid, m_last, m_data, s_ready, busy, grant_id, stall_err);
        end
        do_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_hold: got busy=%b valid=%b required 0 0", busy, m_valid);
        end
    endtask

    task automatic test_single_source();
        logic [7:0] exp3 [3];
        int beat;
        exp3[0] = 8'h11;
        exp3[1] = 8'h22;
        exp3[2] = 8'h33;
        do_reset();
        s_valid[1]    = 1'b1;
        s_data[15:8]  = exp3[0];
        s_last[1]     = 1'b0;
        m_ready       = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_arb_cycle: got busy=%b valid=%b required 0 0", busy, m_valid);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (grant_id !== 2'd1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: got g=%0d busy=%b required 1 1", grant_id, busy);
        end
        beat = 0;
        for (int c = 0; c < 20 && beat < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (m_valid && m_ready) begin
                n_cmp++;
                if (m_data !== exp3[beat] || m_last !== (beat == 2) || s_ready !== 4'b0010) begin
                    n_err++;
                    $display("FAIL single_beat%0d: got d=%h l=%b r=%b required d=%h l=%b r=0010",
                             beat, m_data, m_last, s_ready, exp3[beat], (beat == 2));
                end
                beat++;
            end
            step();
            if (beat < 3) begin
                s_data[15:8] = exp3[beat];
                s_last[1]    = (beat == 2);
            end else begin
                s_valid[1] = 1'b0;
                s_last[1]  = 1'b0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (beat != 3 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: got beats=%0d busy=%b required 3 0", beat, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] rr_dat [NS][4];
        int ptr [NS];
        int pkt;
        int owner;
        logic [7:0] expd;
        logic expl;
        do_reset();
        for (int i = 0; i < NS; i++) begin
            ptr[i] = 0;
            for (int b = 0; b < 4; b++) rr_dat[i][b] = 8'($urandom);
        end
        pkt = 0;
        for (int c = 0; c < 500 && pkt < 8; c++) begin
            for (int i = 0; i < NS; i++) begin
                s_valid[i]         = (ptr[i] < 4);
                s_last[i]          = (ptr[i] % 2 == 1);
                s_data[i*DB +: DB] = rr_dat[i][(ptr[i] < 4) ? ptr[i] : 0];
            end
            m_ready = ($urandom % 4) != 0;
            @(negedge clk);
            if (m_valid && m_ready) begin
                owner = pkt % NS;
                expd  = rr_dat[owner][ptr[owner]];
                expl  = (ptr[owner] % 2 == 1);
                n_cmp++;
                if (grant_id !== 2'(owner) || m_data !== expd || m_last !== expl ||
                    s_ready !== (4'b0001 << owner)) begin
                    n_err++;
                    $display("FAIL rr_pkt%0d: got g=%0d d=%h l=%b r=%b required g=%0d d=%h l=%b",
                             pkt, grant_id, m_data, m_last, s_ready, owner, expd, expl);
                end
                ptr[owner]++;
                if (expl) pkt++;
            end
            step();
        end
        n_cmp++;
        if (pkt != 8) begin
            n_err++;
            $display("FAIL rr_complete: got packets=%0d required 8", pkt);
        end
        s_valid = '0;
        s_last  = '0;
    endtask

    task automatic test_backpressure();
        logic bad;
        do_reset();
        s_valid[2]    = 1'b1;
        s_data[23:16] = 8'h5C;
        s_last[2]     = 1'b0;
        m_ready       = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        n_cmp++;
        if (grant_id !== 2'd2 || m_valid !== 1'b1 || m_data !== 8'h5C) begin
            n_err++;
            $display("FAIL bp_first: got g=%0d v=%b d=%h required 2 1 5c", grant_id, m_valid, m_data);
        end
        step();
        s_data[23:16] = 8'hC5;
        s_last[2]     = 1'b1;
        m_ready       = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (stall_err !== 1'b0 || s_ready[2] !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL bp_hold: got a cycle with stall_err=1, ready=1 or busy=0, required none");
        end
        step();
        m_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (m_valid !== 1'b1 || s_ready[2] !== 1'b1 || m_data !== 8'hC5 || m_last !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got v=%b r=%b d=%h l=%b required 1 1 c5 1",
                     m_valid, s_ready[2], m_data, m_last);
        end
        step();
        s_valid = '0;
        s_last  = '0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_done: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_stall();
        int n;
        logic seen;
        do_reset();
        s_valid[3]    = 1'b1;
        s_data[31:24] = 8'h77;
        s_last[3]     = 1'b0;
        m_ready       = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        n_cmp++;
        if (grant_id !== 2'd3 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL stall_grant: got g=%0d busy=%b required 3 1", grant_id, busy);
        end
        step();
        s_valid[3]   = 1'b0;
        s_valid[0]   = 1'b1;
        s_data[7:0]  = 8'h0D;
        s_last[0]    = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (stall_err === 1'b1) seen = 1'b1;
            else if (busy === 1'b1) n++;
        end
        n_cmp++;
        if (!seen || n != STO || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stall_timing: got seen=%b idle_cycles=%0d busy=%b required 1 %0d 0",
                     seen, n, busy, STO);
        end
        @(negedge clk);
        n_cmp++;
        if (stall_err !== 1'b0 || busy !== 1'b1 || grant_id !== 2'd0 || m_data !== 8'h0D) begin
            n_err++;
            $display("FAIL stall_regrant: got se=%b busy=%b g=%0d d=%h required 0 1 0 0d",
                     stall_err, busy, grant_id, m_data);
        end
        step();
        s_valid = '0;
        s_last  = '0;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        s_valid[1]   = 1'b1;
        s_data[15:8] = 8'h40;
        s_last[1]    = 1'b0;
        m_ready      = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        n_cmp++;
        if (grant_id !== 2'd1 || m_valid !== 1'b1 || m_data !== 8'h40) begin
            n_err++;
            $display("FAIL rstmid_beat1: got g=%0d v=%b d=%h required 1 1 40", grant_id, m_valid, m_data);
        end
        step();
        s_data[15:8] = 8'h41;
        rst_n        = 1'b0;
        s_valid[0]   = 1'b1;
        s_data[7:0]  = 8'hC3;
        s_last[0]    = 1'b1;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({m_valid, m_last, m_data, s_ready, busy, grant_id, stall_err} !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got v=%b l=%b d=%h r=%b busy=%b g=%0d se=%b required all zero",
                     m_valid, m_last, m_data, s_ready, busy, grant_id, stall_err);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if (grant_id !== 2'd0 || busy !== 1'b1 || m_data !== 8'hC3) begin
            n_err++;
            $display("FAIL rstmid_regrant: got g=%0d busy=%b d=%h required 0 1 c3", grant_id, busy, m_data);
        end
        step();
        s_valid = '0;
        s_last  = '0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] expb [2];
        int hs_cyc [2];
        int k;
        expb[0] = 8'hA5;
        expb[1] = 8'h5A;
        do_reset();
        s_valid[0]  = 1'b1;
        s_data[7:0] = expb[0];
        s_last[0]   = 1'b1;
        m_ready     = 1'b1;
        k = 0;
        hs_cyc[0] = 0;
        hs_cyc[1] = 0;
        for (int c = 0; c < 20 && k < 2; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                n_cmp++;
                if (m_data !== expb[k] || grant_id !== 2'd0 || m_last !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_beat%0d: got d=%h g=%0d l=%b required %h 0 1",
                             k, m_data, grant_id, m_last, expb[k]);
                end
                hs_cyc[k] = c;
                k++;
                step();
                if (k == 1) s_data[7:0] = expb[1];
                else s_valid[0] = 1'b0;
            end
        end
        n_cmp++;
        if (k != 2 || hs_cyc[1] - hs_cyc[0] != 2) begin
            n_err++;
            $display("FAIL b2b_spacing: got beats=%0d gap=%0d required 2 2", k, hs_cyc[1] - hs_cyc[0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_stall();
        test_reset_mid_packet();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axis_uart_tx_arbiter.md
Name: axis_uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single AXI-Stream input of the AXIS-UART transmit/loopback core between NUM_SRC stream sources.
- Sits between the requesters and the UART core's axis_data/axis_valid/axis_last inputs.
- Holds a grant from the first beat to the beat carrying last, so packets never interleave on the UART line.
- A stall watchdog releases a grant whose owner stops presenting data mid-packet.

Parameters:
- NUM_SRC, 4: number of requesting stream sources; 2..8.
- DATA_BITS, 8: stream data width; matches the UART core's DATA_BITS.
- STALL_TIMEOUT, 255: consecutive granted-source-invalid cycles in XFER before forced release; 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- s_axis_data  in  NUM_SRC*DATA_BITS  source data, flat; source i at [i*DATA_BITS +: DATA_BITS].
- s_axis_valid  in  NUM_SRC  per-source valid.
- s_axis_last  in  NUM_SRC  per-source end-of-packet flag.
- s_axis_ready  out  NUM_SRC  per-source ready.
- m_axis_data  out  DATA_BITS  data to UART core.
- m_axis_valid  out  1  valid to UART core.
- m_axis_last  out  1  last to UART core.
- m_axis_ready  in  1  UART core accepts beat.
- grant_id  out  clog2(NUM_SRC)  index of current/most recent owner.
- busy  out  1  high while in XFER.
- stall_err  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, last_grant=NUM_SRC-1 (source 0 has first priority), grant_id=0, stall counter=0, stall_err=0.
- Outputs while in reset or IDLE: m_axis_valid=0, m_axis_last=0, m_axis_data=0, s_axis_ready=0.
- Reset asserted mid-packet aborts the packet. There is no recovery beat, and the partial packet is the source's problem.
- States are IDLE and XFER.
- IDLE, arbitration:
  - When any s_axis_valid is high, select the first valid source scanning last_grant+1, last_grant+2, ... modulo NUM_SRC.
  - Register the winner into grant_id and go to XFER. Arbitration latency is 1 cycle; no beat is passed in the IDLE cycle.
  - If no source is valid, stay in IDLE.
- XFER, combinational pass-through from the granted source g:
  - m_axis_data = s_axis_data[g], m_axis_valid = s_axis_valid[g], m_axis_last = s_axis_last[g].
  - s_axis_ready[g] = m_axis_ready; all other ready bits are 0.
  - busy=1.
- XFER exit on last:
  - On a handshake (m_axis_valid & m_axis_ready) with m_axis_last=1: last_grant<=g, state<=IDLE.
  - The next packet starts at the earliest 1 cycle later, because IDLE is never skipped.
- Stall watchdog:
  - In XFER, the counter increments each cycle s_axis_valid[g]=0 and clears on any cycle s_axis_valid[g]=1.
  - Backpressure (valid=1, ready=0) does not count.
  - When the counter reaches STALL_TIMEOUT: stall_err=1 for that one cycle, last_grant<=g, counter<=0, state<=IDLE.
  - No last is synthesised downstream.
- Requests and grants:
  - A source may drop valid in IDLE without penalty; requests are level-sensitive and nothing is latched.
  - Simultaneous requests resolve purely by rotation order.
  - A single persistent requester is re-granted after each packet, paying the 1 IDLE cycle.
- Single-beat packet (valid & last on the first beat): IDLE -> XFER -> IDLE, 1 beat transferred.
- grant_id holds its value in IDLE until the next arbitration.
- m_axis_data is a don't-care whenever m_axis_valid=0 in XFER; in IDLE it is forced to 0.

Test Plan:
- Reset, then source 1 sends 3 beats 0x11,0x22,0x33 (last on 0x33) with m_axis_ready=1 -> grant_id=1 one cycle after valid, UART sees exactly 0x11,0x22,0x33 with last on the third beat, busy falls the next cycle.
- All 4 sources valid continuously, each sending 2-beat packets -> grant order 0,1,2,3,0, and no beats from different sources interleave.
- Source 2 mid-packet while m_axis_ready held 0 for 300 cycles -> no stall_err, s_axis_ready[2]=0, and the beat transfers when ready returns.
- Source 3 sends 1 beat without last, then drops valid, with STALL_TIMEOUT=255 -> stall_err pulses once 255 cycles later, state returns to IDLE, and a waiting source 0 is granted next.
- Reset pulsed during beat 2 of a 4-beat packet from source 1 -> all outputs 0 the cycle after, and the first post-reset grant goes to source 0 when sources 0 and 1 are both valid.
- Source 0 only, back-to-back single-beat packets 0xA5,0x5A -> each transferred with exactly 1 idle cycle between handshakes, grant_id stays 0.
